// File: rtl/full_adder_1b.sv
// full_adder_1b: 1-bit full adder with zero-latency sum/carry outputs, a registered
// result stage and saturating operation/carry statistics counters.
module full_adder_1b #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c_in,
    input  logic             en,
    input  logic             clr,
    output logic             s,
    output logic             c_out,
    output logic             s_q,
    output logic             c_out_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             w_s;
    logic             w_c;
    logic             r_s;
    logic             r_c;
    logic             r_valid;
    logic [CNT_W-1:0] r_op_cnt;
    logic [CNT_W-1:0] r_carry_cnt;

    // Pure gates with no clock or reset dependence so ripple chains see zero latency.
    assign w_s = a ^ b ^ c_in;
    assign w_c = (a & b) | (a & c_in) | (b & c_in);

    assign s         = w_s;
    assign c_out     = w_c;
    assign s_q       = r_s;
    assign c_out_q   = r_c;
    assign valid_q   = r_valid;
    assign op_cnt    = r_op_cnt;
    assign carry_cnt = r_carry_cnt;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s     <= 1'b0;
            r_c     <= 1'b0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_s     <= w_s;
            r_c     <= w_c;
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    // clr wins over en; each counter sticks at all-ones independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_cnt    <= '0;
            r_carry_cnt <= '0;
        end else if (clr) begin
            r_op_cnt    <= '0;
            r_carry_cnt <= '0;
        end else if (en) begin
            if (r_op_cnt != CNT_MAX) begin
                r_op_cnt <= r_op_cnt + CNT_ONE;
            end
            if (w_c && (r_carry_cnt != CNT_MAX)) begin
                r_carry_cnt <= r_carry_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_full_adder_1b.sv
// Self-checking bench for full_adder_1b: truth-table sweep plus a scoreboard of
// expected registered/counter values for a CNT_W=8 and a CNT_W=2 instance.
module tb_full_adder_1b;

    logic clk = 1'b0;
    logic rst_n, a, b, c_in, en, clr;
    logic s8, c8, sq8, cq8, v8;
    logic s2, c2, sq2, cq2, v2;
    logic [7:0] op8, cy8;
    logic [1:0] op2, cy2;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       s_q;
        logic       c_q;
        logic       v;
        logic [7:0] op8;
        logic [7:0] cy8;
        logic [1:0] op2;
        logic [1:0] cy2;
    } exp_t;

    exp_t sb[$];
    exp_t m;

    full_adder_1b #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .en(en), .clr(clr),
        .s(s8), .c_out(c8), .s_q(sq8), .c_out_q(cq8), .valid_q(v8),
        .op_cnt(op8), .carry_cnt(cy8)
    );

    full_adder_1b #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .en(en), .clr(clr),
        .s(s2), .c_out(c2), .s_q(sq2), .c_out_q(cq2), .valid_q(v2),
        .op_cnt(op2), .carry_cnt(cy2)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Truth table written out literally, {s, c_out} for {a, b, c_in}.
    function automatic logic [1:0] tt(input logic ia, input logic ib, input logic ic);
        case ({ia, ib, ic})
            3'b000:  tt = 2'b00;
            3'b010:  tt = 2'b10;
            3'b100:  tt = 2'b10;
            3'b110:  tt = 2'b01;
            3'b001:  tt = 2'b10;
            3'b011:  tt = 2'b01;
            3'b101:  tt = 2'b01;
            default: tt = 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        m = '{s_q: 1'b0, c_q: 1'b0, v: 1'b0, op8: 8'd0, cy8: 8'd0, op2: 2'd0, cy2: 2'd0};
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, ".s_q8"},  sq8, e.s_q);
        check({tag, ".cq8"},   cq8, e.c_q);
        check({tag, ".v8"},    v8,  e.v);
        check({tag, ".op8"},   op8, e.op8);
        check({tag, ".cy8"},   cy8, e.cy8);
        check({tag, ".s_q2"},  sq2, e.s_q);
        check({tag, ".cq2"},   cq2, e.c_q);
        check({tag, ".v2"},    v2,  e.v);
        check({tag, ".op2"},   op2, e.op2);
        check({tag, ".cy2"},   cy2, e.cy2);
    endtask

    // Drive one cycle at negedge, push the expected post-edge state, compare after the edge.
    task automatic drive_cycle(input string tag, input logic ia, input logic ib,
                               input logic ic, input logic ien, input logic iclr);
        logic [1:0] r;
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; c_in = ic; en = ien; clr = iclr;
        r = tt(ia, ib, ic);
        if (ien) begin
            m.s_q = r[1];
            m.c_q = r[0];
            m.v   = 1'b1;
        end else begin
            m.v = 1'b0;
        end
        if (iclr) begin
            m.op8 = '0; m.cy8 = '0; m.op2 = '0; m.cy2 = '0;
        end else if (ien) begin
            if (m.op8 != 8'hFF) m.op8 = m.op8 + 8'd1;
            if (m.op2 != 2'h3)  m.op2 = m.op2 + 2'd1;
            if (r[0] && m.cy8 != 8'hFF) m.cy8 = m.cy8 + 8'd1;
            if (r[0] && m.cy2 != 2'h3)  m.cy2 = m.cy2 + 2'd1;
        end
        sb.push_back(m);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check_regs(tag, e);
        end
    endtask

    logic [2:0] combos [8];
    logic [1:0] r;

    initial begin
        combos = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
        rst_n = 1'b0; a = 1'b0; b = 1'b0; c_in = 1'b0; en = 1'b0; clr = 1'b0;
        model_reset();
        #2;
        check_regs("reset", m);

        // Combinational sweep while reset is held.
        for (int i = 0; i < 8; i++) begin
            {a, b, c_in} = combos[i];
            #1;
            r = tt(combos[i][2], combos[i][1], combos[i][0]);
            check($sformatf("comb%0d.s8", i), s8, r[1]);
            check($sformatf("comb%0d.c8", i), c8, r[0]);
            check($sformatf("comb%0d.s2", i), s2, r[1]);
        end

        @(negedge clk);
        rst_n = 1'b1;

        // Registered capture then hold.
        drive_cycle("cap", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("cap.s_q_const", sq8, 1'b0);
        check("cap.cq_const", cq8, 1'b1);
        drive_cycle("hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hold.v_const", v8, 1'b0);
        check("hold.cq_const", cq8, 1'b1);

        // Full sweep from cleared counters.
        drive_cycle("clr0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive_cycle($sformatf("sweep%0d", i), combos[i][2], combos[i][1], combos[i][0],
                        1'b1, 1'b0);
        end
        check("sweep.op8_const", op8, 8'd8);
        check("sweep.cy8_const", cy8, 8'd4);

        // Saturation on the 2-bit instance.
        drive_cycle("clr1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive_cycle($sformatf("sat%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        end
        check("sat.op2_const", op2, 2'd3);
        check("sat.cy2_const", cy2, 2'd3);
        drive_cycle("clr_en", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        check("clr_en.op2_const", op2, 2'd0);
        check("clr_en.cy8_const", cy8, 8'd0);
        check("clr_en.s_q_const", sq8, 1'b1);

        // Build op_cnt=5 with s_q=1, then reset asynchronously between edges.
        drive_cycle("clr2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle($sformatf("pre%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        drive_cycle("pre4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("pre.op8_const", op8, 8'd5);
        check("pre.s_q_const", sq8, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst", m);
        a = 1'b1; b = 1'b1; c_in = 1'b0; en = 1'b0; clr = 1'b0;
        #1;
        check("async_rst.s8", s8, 1'b0);
        check("async_rst.c8", c8, 1'b1);

        // Release reset and capture on the first enabled edge.
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle("release", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("release.op8_const", op8, 8'd1);
        check("release.cy8_const", cy8, 8'd1);

        if (sb.size() != 0) check("sb_leftover", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
